// File: rtl/disaggregator_if.sv
// ============================================================================
//  Module   : disaggregator_if
//  Brief    : Upstream (wide FIFO head) and downstream (narrow FIFO tail)
//             handshake bundle for the disaggregator.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface disaggregator_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int FETCH_WIDTH = 2
);
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
    logic                              sender_empty_n;
    logic                              sender_deq;
    logic [DATA_WIDTH-1:0]             receiver_data;
    logic                              receiver_full_n;
    logic                              receiver_enq;

    // master: the disaggregator itself; slave: the surrounding FIFOs
    modport master (
        input  sender_data, sender_empty_n, receiver_full_n,
        output sender_deq, receiver_data, receiver_enq
    );
    modport slave (
        output sender_data, sender_empty_n, receiver_full_n,
        input  sender_deq, receiver_data, receiver_enq
    );
endinterface

`default_nettype wire

// File: rtl/disaggregator.sv
// ============================================================================
//  Module   : disaggregator
//  Brief    : Pops one FETCH_WIDTH*DATA_WIDTH word and emits it as
//             FETCH_WIDTH narrow words, one per clock, no reload bubble.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module disaggregator #(
    parameter int DATA_WIDTH  = 8,
    parameter int FETCH_WIDTH = 2,
    parameter int MSB_FIRST   = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    disaggregator_if.master  bus,
    input  wire logic        flush,
    output logic             busy
);
    localparam int c_IDX_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(FETCH_WIDTH - 1);

    logic [FETCH_WIDTH*DATA_WIDTH-1:0] r_buf;
    logic                              r_vld;
    logic [c_IDX_W-1:0]                r_idx;

    logic                              w_last;
    logic                              w_enq;
    logic                              w_deq;
    logic [c_IDX_W-1:0]                w_sel;
    logic [DATA_WIDTH-1:0]             w_lane [FETCH_WIDTH];

    generate
        for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
            assign w_lane[g] = r_buf[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_last = (r_idx == c_LAST);
    assign w_sel  = (MSB_FIRST != 0) ? (c_LAST - r_idx) : r_idx;
    assign w_enq  = r_vld & bus.receiver_full_n;
    // Reload while the last lane leaves keeps the narrow side at one word/clk
    assign w_deq  = bus.sender_empty_n & ~flush & ~rst & (~r_vld | (w_last & w_enq));

    assign bus.receiver_data = w_lane[w_sel];
    assign bus.receiver_enq  = w_enq;
    assign bus.sender_deq    = w_deq;
    assign busy              = r_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf <= '0;
            r_vld <= 1'b0;
            r_idx <= '0;
        end else if (flush) begin
            r_vld <= 1'b0;
            r_idx <= '0;
        end else if (w_deq) begin
            r_buf <= bus.sender_data;
            r_vld <= 1'b1;
            r_idx <= '0;
        end else if (w_enq) begin
            if (w_last) begin
                r_vld <= 1'b0;
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + c_IDX_W'(1);
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_disaggregator.sv
// ============================================================================
//  Module   : tb_disaggregator
//  Brief    : Self-checking bench for disaggregator (8-bit lanes, 2 per word).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_disaggregator;
    logic clk;
    logic rst;
    logic flush;
    logic busy;
    logic flush2;
    logic busy2;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] src_q[$];

    disaggregator_if #(.DATA_WIDTH(8), .FETCH_WIDTH(2)) bus ();
    disaggregator_if #(.DATA_WIDTH(8), .FETCH_WIDTH(2)) bus2 ();

    disaggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(2), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush(flush), .busy(busy)
    );
    disaggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(2), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .bus(bus2), .flush(flush2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock of the upstream FIFO model: head of src_q is presented, popped on deq
    task automatic step(input bit ep, input bit fn, input bit fl,
                        output bit deq, output bit enq, output logic [7:0] d, output bit bsy);
        bus.sender_data     = (src_q.size() > 0) ? src_q[0] : 16'h0000;
        bus.sender_empty_n  = ep && (src_q.size() > 0);
        bus.receiver_full_n = fn;
        flush               = fl;
        #2;
        deq = bus.sender_deq;
        enq = bus.receiver_enq;
        d   = bus.receiver_data;
        bsy = busy;
        @(posedge clk);
        if (deq && src_q.size() > 0) void'(src_q.pop_front());
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sender_data = 16'h1234; bus.sender_empty_n = 1'b1; bus.receiver_full_n = 1'b1;
        flush = 1'b0;
        bus2.sender_data = 16'h0; bus2.sender_empty_n = 1'b0; bus2.receiver_full_n = 1'b1;
        flush2 = 1'b0;
        @(posedge clk); #1;
        n_vec += 4;
        if (bus.sender_deq !== 1'b0) begin n_err++; $display("FAIL reset_deq: got %b expected 0", bus.sender_deq); end
        if (bus.receiver_enq !== 1'b0) begin n_err++; $display("FAIL reset_enq: got %b expected 0", bus.receiver_enq); end
        if (bus.receiver_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", bus.receiver_data); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        bus.sender_empty_n = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        bit deq, enq, bsy; logic [7:0] d; int e = 0;
        bit exp_deq [8] = '{1, 0, 1, 0, 1, 0, 0, 0};
        bit exp_enq [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        src_q = '{16'h0100, 16'h0302, 16'h0504};
        for (int c = 0; c < 8; c++) begin
            step(1, 1, 0, deq, enq, d, bsy);
            n_vec += 2;
            if (deq !== exp_deq[c]) begin n_err++; $display("FAIL stream_deq c%0d: got %b expected %b", c, deq, exp_deq[c]); end
            if (enq !== exp_enq[c]) begin n_err++; $display("FAIL stream_enq c%0d: got %b expected %b", c, enq, exp_enq[c]); end
            if (enq) begin
                n_vec++;
                if (d !== 8'(e)) begin n_err++; $display("FAIL stream_data c%0d: got %h expected %h", c, d, 8'(e)); end
                e++;
            end
        end
    endtask

    task automatic test_msb_first();
        bus2.sender_data = 16'hA1B2; bus2.sender_empty_n = 1'b1; bus2.receiver_full_n = 1'b1;
        #2;
        n_vec++;
        if (bus2.sender_deq !== 1'b1) begin n_err++; $display("FAIL msb_deq: got %b expected 1", bus2.sender_deq); end
        @(posedge clk); #1;
        bus2.sender_empty_n = 1'b0;
        #2;
        n_vec += 2;
        if (bus2.receiver_enq !== 1'b1) begin n_err++; $display("FAIL msb_enq0: got %b expected 1", bus2.receiver_enq); end
        if (bus2.receiver_data !== 8'hA1) begin n_err++; $display("FAIL msb_lane0: got %h expected a1", bus2.receiver_data); end
        @(posedge clk); #1; #2;
        n_vec += 2;
        if (bus2.receiver_enq !== 1'b1) begin n_err++; $display("FAIL msb_enq1: got %b expected 1", bus2.receiver_enq); end
        if (bus2.receiver_data !== 8'hB2) begin n_err++; $display("FAIL msb_lane1: got %h expected b2", bus2.receiver_data); end
        @(posedge clk); #1; #2;
        n_vec++;
        if (bus2.receiver_enq !== 1'b0) begin n_err++; $display("FAIL msb_idle: got %b expected 0", bus2.receiver_enq); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit deq, enq, bsy; logic [7:0] d;
        bit         exp_deq [5] = '{0, 1, 0, 0, 0};
        bit         exp_enq [5] = '{1, 1, 1, 1, 0};
        logic [7:0] exp_d   [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
        src_q = '{16'h0100, 16'h0302};
        step(1, 0, 0, deq, enq, d, bsy);
        n_vec++;
        if (deq !== 1'b1) begin n_err++; $display("FAIL stall_first_deq: got %b expected 1", deq); end
        for (int c = 0; c < 5; c++) begin
            step(1, 0, 0, deq, enq, d, bsy);
            n_vec += 3;
            if (enq !== 1'b0) begin n_err++; $display("FAIL stall_enq c%0d: got %b expected 0", c, enq); end
            if (deq !== 1'b0) begin n_err++; $display("FAIL stall_deq c%0d: got %b expected 0", c, deq); end
            if (d !== 8'h00) begin n_err++; $display("FAIL stall_data c%0d: got %h expected 00", c, d); end
        end
        for (int c = 0; c < 5; c++) begin
            step(1, 1, 0, deq, enq, d, bsy);
            n_vec += 2;
            if (deq !== exp_deq[c]) begin n_err++; $display("FAIL release_deq c%0d: got %b expected %b", c, deq, exp_deq[c]); end
            if (enq !== exp_enq[c]) begin n_err++; $display("FAIL release_enq c%0d: got %b expected %b", c, enq, exp_enq[c]); end
            if (exp_enq[c]) begin
                n_vec++;
                if (d !== exp_d[c]) begin n_err++; $display("FAIL release_data c%0d: got %h expected %h", c, d, exp_d[c]); end
            end
        end
    endtask

    task automatic test_random();
        bit deq, enq, bsy, ep, fn; logic [7:0] d;
        int wk = 0, popped = 0, rx = 0;
        src_q.delete();
        for (int c = 0; c < 2000; c++) begin
            while (src_q.size() < 4) begin
                src_q.push_back({8'(2*wk + 1), 8'(2*wk)});
                wk++;
            end
            ep = ($urandom_range(0, 3) != 0);
            fn = ($urandom_range(0, 3) != 0);
            step(ep, fn, 0, deq, enq, d, bsy);
            n_vec += 2;
            if (deq && !ep) begin n_err++; $display("FAIL rand_deq_empty c%0d: got deq=1 expected 0", c); end
            if (enq && !fn) begin n_err++; $display("FAIL rand_enq_full c%0d: got enq=1 expected 0", c); end
            if (deq) popped++;
            if (enq) begin
                n_vec++;
                if (d !== 8'(rx)) begin n_err++; $display("FAIL rand_data #%0d: got %h expected %h", rx, d, 8'(rx)); end
                rx++;
            end
        end
        for (int c = 0; c < 8; c++) begin
            step(0, 1, 0, deq, enq, d, bsy);
            if (enq) begin
                n_vec++;
                if (d !== 8'(rx)) begin n_err++; $display("FAIL drain_data #%0d: got %h expected %h", rx, d, 8'(rx)); end
                rx++;
            end
        end
        n_vec += 2;
        if (rx != 2 * popped) begin n_err++; $display("FAIL rand_count: got %0d words expected %0d", rx, 2 * popped); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rand_drain_busy: got %b expected 0", busy); end
        src_q.delete();
    endtask

    task automatic test_reset_mid();
        bit deq, enq, bsy; logic [7:0] d;
        bit         exp_deq [4] = '{1, 0, 0, 0};
        bit         exp_enq [4] = '{0, 1, 1, 0};
        logic [7:0] exp_d   [4] = '{8'h00, 8'h02, 8'h03, 8'h00};
        src_q = '{16'h0100, 16'h0302};
        step(1, 1, 0, deq, enq, d, bsy);
        step(1, 1, 0, deq, enq, d, bsy);
        n_vec++;
        if (!(enq === 1'b1 && d === 8'h00)) begin n_err++; $display("FAIL rstmid_lane0: got enq=%b data=%h expected 1/00", enq, d); end
        rst = 1'b1;
        #1;
        n_vec += 4;
        if (bus.receiver_enq !== 1'b0) begin n_err++; $display("FAIL rstmid_enq: got %b expected 0", bus.receiver_enq); end
        if (bus.sender_deq !== 1'b0) begin n_err++; $display("FAIL rstmid_deq: got %b expected 0", bus.sender_deq); end
        if (bus.receiver_data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h expected 00", bus.receiver_data); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        n_vec++;
        if (bus.sender_deq !== 1'b0) begin n_err++; $display("FAIL rstmid_hold_deq: got %b expected 0", bus.sender_deq); end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(1, 1, 0, deq, enq, d, bsy);
            n_vec += 2;
            if (deq !== exp_deq[c]) begin n_err++; $display("FAIL rstmid_deq c%0d: got %b expected %b", c, deq, exp_deq[c]); end
            if (enq !== exp_enq[c]) begin n_err++; $display("FAIL rstmid_enq c%0d: got %b expected %b", c, enq, exp_enq[c]); end
            if (exp_enq[c]) begin
                n_vec++;
                if (d !== exp_d[c]) begin n_err++; $display("FAIL rstmid_data c%0d: got %h expected %h", c, d, exp_d[c]); end
            end
        end
    endtask

    task automatic test_flush();
        bit deq, enq, bsy; logic [7:0] d;
        bit         exp_deq [4] = '{1, 0, 0, 0};
        bit         exp_enq [4] = '{0, 1, 1, 0};
        logic [7:0] exp_d   [4] = '{8'h00, 8'h02, 8'h03, 8'h00};
        src_q = '{16'h0100, 16'h0302};
        step(1, 1, 0, deq, enq, d, bsy);
        step(1, 1, 0, deq, enq, d, bsy);
        n_vec++;
        if (!(enq === 1'b1 && d === 8'h00)) begin n_err++; $display("FAIL flush_lane0: got enq=%b data=%h expected 1/00", enq, d); end
        step(1, 0, 1, deq, enq, d, bsy);
        n_vec += 2;
        if (deq !== 1'b0) begin n_err++; $display("FAIL flush_deq: got %b expected 0", deq); end
        if (enq !== 1'b0) begin n_err++; $display("FAIL flush_enq: got %b expected 0", enq); end
        for (int c = 0; c < 4; c++) begin
            step(1, 1, 0, deq, enq, d, bsy);
            if (c == 0) begin
                n_vec++;
                if (bsy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", bsy); end
            end
            n_vec += 2;
            if (deq !== exp_deq[c]) begin n_err++; $display("FAIL postflush_deq c%0d: got %b expected %b", c, deq, exp_deq[c]); end
            if (enq !== exp_enq[c]) begin n_err++; $display("FAIL postflush_enq c%0d: got %b expected %b", c, enq, exp_enq[c]); end
            if (exp_enq[c]) begin
                n_vec++;
                if (d !== exp_d[c]) begin n_err++; $display("FAIL postflush_data c%0d: got %h expected %h", c, d, exp_d[c]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_msb_first();
        test_stall();
        test_random();
        test_reset_mid();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
